// File: rtl/shift_reg_loader.sv
// Sequencing controller feeding the systolic-array shift_reg buffer: LOAD streams
// LENGTH words from operand memory into shift_reg, DRAIN streams them back out to memory.
module shift_reg_loader #(
    parameter int DATA_WIDTH = 8,
    parameter int LENGTH     = 4,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  mode,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rd_en,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic                  mem_wr_en,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    output logic [1:0]            ctrl_code,
    output logic [DATA_WIDTH-1:0] data_write,
    input  logic [DATA_WIDTH-1:0] data_read
);

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

    localparam int CNT_W = $clog2(LENGTH + 1) + 1;
    localparam logic [CNT_W-1:0] LAST_LOAD  = CNT_W'(LENGTH);
    localparam logic [CNT_W-1:0] LAST_DRAIN = CNT_W'(LENGTH - 1);

    localparam logic [1:0] CTRL_HOLD = 2'b00;
    localparam logic [1:0] CTRL_IN   = 2'b10;
    localparam logic [1:0] CTRL_OUT  = 2'b11;

    state_t                  state, next_state;
    logic [CNT_W-1:0]        cnt, next_cnt;
    logic [ADDR_WIDTH-1:0]   next_addr;
    logic                    next_busy, next_done, next_rd_en, next_wr_en;
    logic [1:0]              next_ctrl;

    // The registered outputs are computed one cycle ahead from the next state, so
    // every strobe lines up with the cycle numbering seen by memory and shift_reg.
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        next_state = state;
        next_cnt   = cnt;
        next_addr  = mem_addr;
        next_busy  = 1'b0;
        next_done  = 1'b0;
        next_rd_en = 1'b0;
        next_wr_en = 1'b0;
        next_ctrl  = CTRL_HOLD;

        unique case (state)
            IDLE: begin
                if (start) begin
                    next_cnt  = '0;
                    next_addr = base_addr;
                    next_busy = 1'b1;
                    if (mode) begin
                        next_state = DRAIN;
                        next_wr_en = 1'b1;
                        next_ctrl  = CTRL_OUT;
                    end else begin
                        next_state = LOAD;
                        next_rd_en = 1'b1;
                    end
                end
            end
            LOAD: begin
                // Read data trails the read strobe by one cycle, hence LENGTH+1 cycles.
                if (cnt == LAST_LOAD) begin
                    next_state = DONE;
                    next_done  = 1'b1;
                end else begin
                    next_cnt  = cnt + 1'b1;
                    next_busy = 1'b1;
                    next_ctrl = CTRL_IN;
                    if (cnt < LAST_DRAIN) begin
                        next_rd_en = 1'b1;
                        next_addr  = mem_addr + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (cnt == LAST_DRAIN) begin
                    next_state = DONE;
                    next_done  = 1'b1;
                end else begin
                    next_cnt   = cnt + 1'b1;
                    next_addr  = mem_addr + 1'b1;
                    next_busy  = 1'b1;
                    next_wr_en = 1'b1;
                    next_ctrl  = CTRL_OUT;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            mem_addr  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            mem_rd_en <= 1'b0;
            mem_wr_en <= 1'b0;
            ctrl_code <= CTRL_HOLD;
        end else begin
            state     <= next_state;
            cnt       <= next_cnt;
            mem_addr  <= next_addr;
            busy      <= next_busy;
            done      <= next_done;
            mem_rd_en <= next_rd_en;
            mem_wr_en <= next_wr_en;
            ctrl_code <= next_ctrl;
        end
    end

    // Data paths are pass-through: shift_reg head goes straight to memory, read data straight in.
    assign mem_wr_data = (state == DRAIN) ? data_read : '0;
    assign data_write  = (ctrl_code == CTRL_IN) ? mem_rd_data : '0;

endmodule

// File: tb/tb_shift_reg_loader.sv
// Directed bench for shift_reg_loader with a behavioural operand memory and
// a four-word shift_reg model attached to its ports.
module tb_shift_reg_loader;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       mode;
    logic [7:0] base_addr;
    logic       busy, done, mem_rd_en, mem_wr_en;
    logic [7:0] mem_addr, mem_rd_data, mem_wr_data, data_write, data_read;
    logic [1:0] ctrl_code;

    logic       bd_en;
    logic [7:0] bd_addr, bd_data;
    logic [7:0] mem [256];
    logic [7:0] sr [4];

    int checks = 0;
    int errors = 0;

    shift_reg_loader #(.DATA_WIDTH(8), .LENGTH(4), .ADDR_WIDTH(8)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .base_addr(base_addr),
        .busy(busy), .done(done), .mem_addr(mem_addr), .mem_rd_en(mem_rd_en),
        .mem_rd_data(mem_rd_data), .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data),
        .ctrl_code(ctrl_code), .data_write(data_write), .data_read(data_read)
    );

    always #5 clk = ~clk;

    // Synchronous-read memory with a backdoor write port for preloading.
    always @(posedge clk) begin
        if (bd_en) mem[bd_addr] <= bd_data;
        else if (mem_wr_en) mem[mem_addr] <= mem_wr_data;
        if (mem_rd_en) mem_rd_data <= mem[mem_addr];
    end

    // shift_reg model: shift-in appends at the tail, head is sr[0].
    always @(posedge clk) begin
        if (ctrl_code == 2'b10 || ctrl_code == 2'b11) begin
            for (int i = 0; i < 3; i++) sr[i] <= sr[i+1];
            sr[3] <= (ctrl_code == 2'b10) ? data_write : 8'h00;
        end
    end
    assign data_read = sr[0];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        bd_en = 1'b1; bd_addr = a; bd_data = d;
        tick();
        bd_en = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; mode = 1'b0; base_addr = 8'h00;
        bd_en = 1'b0; bd_addr = 8'h00; bd_data = 8'h00;
        for (int i = 0; i < 4; i++) sr[i] = 8'h00;
        tick(); tick();
        poke(8'h10, 8'd5); poke(8'h11, 8'd6); poke(8'h12, 8'd7); poke(8'h13, 8'd8);
        poke(8'hFE, 8'd1); poke(8'hFF, 8'd2); poke(8'h00, 8'd3); poke(8'h01, 8'd4);

        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ctrl", 32'(ctrl_code), 32'd0);
        check("rst_rd", 32'(mem_rd_en), 32'd0);
        check("rst_wr", 32'(mem_wr_en), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_wdata", 32'(mem_wr_data), 32'd0);
        reset = 1'b0;
        tick();

        // LOAD base 0x10, with an ignored start pulse in cycle 2.
        start = 1'b1; mode = 1'b0; base_addr = 8'h10;
        tick();
        start = 1'b0;
        check("ld0_busy", 32'(busy), 32'd1);
        check("ld0_rd", 32'(mem_rd_en), 32'd1);
        check("ld0_addr", 32'(mem_addr), 32'h10);
        check("ld0_ctrl", 32'(ctrl_code), 32'd0);
        tick();
        check("ld1_addr", 32'(mem_addr), 32'h11);
        check("ld1_ctrl", 32'(ctrl_code), 32'h2);
        check("ld1_dw", 32'(data_write), 32'd5);
        tick();
        check("ld2_addr", 32'(mem_addr), 32'h12);
        check("ld2_dw", 32'(data_write), 32'd6);
        start = 1'b1; mode = 1'b1; base_addr = 8'h40;
        tick();
        start = 1'b0;
        check("ld3_addr", 32'(mem_addr), 32'h13);
        check("ld3_ctrl", 32'(ctrl_code), 32'h2);
        check("ld3_dw", 32'(data_write), 32'd7);
        check("ld3_wr", 32'(mem_wr_en), 32'd0);
        tick();
        check("ld4_rd", 32'(mem_rd_en), 32'd0);
        check("ld4_ctrl", 32'(ctrl_code), 32'h2);
        check("ld4_dw", 32'(data_write), 32'd8);
        check("ld4_busy", 32'(busy), 32'd1);
        tick();
        check("ld5_done", 32'(done), 32'd1);
        check("ld5_busy", 32'(busy), 32'd0);
        check("ld5_ctrl", 32'(ctrl_code), 32'd0);
        start = 1'b1; mode = 1'b0; base_addr = 8'h30;
        tick();
        start = 1'b0;
        check("postdone_busy", 32'(busy), 32'd0);
        check("postdone_done", 32'(done), 32'd0);
        check("postdone_rd", 32'(mem_rd_en), 32'd0);
        tick();
        check("postdone_busy2", 32'(busy), 32'd0);
        check("sr0", 32'(sr[0]), 32'd5);
        check("sr1", 32'(sr[1]), 32'd6);
        check("sr2", 32'(sr[2]), 32'd7);
        check("sr3", 32'(sr[3]), 32'd8);

        // DRAIN to base 0x20.
        start = 1'b1; mode = 1'b1; base_addr = 8'h20;
        tick();
        start = 1'b0;
        check("dr0_ctrl", 32'(ctrl_code), 32'h3);
        check("dr0_wr", 32'(mem_wr_en), 32'd1);
        check("dr0_busy", 32'(busy), 32'd1);
        check("dr0_addr", 32'(mem_addr), 32'h20);
        check("dr0_wdata", 32'(mem_wr_data), 32'd5);
        check("dr0_rd", 32'(mem_rd_en), 32'd0);
        for (int i = 1; i < 4; i++) begin
            tick();
            check("dr_ctrl", 32'(ctrl_code), 32'h3);
            check("dr_addr", 32'(mem_addr), 32'(8'h20 + i));
            check("dr_wdata", 32'(mem_wr_data), 32'(5 + i));
            check("dr_rd", 32'(mem_rd_en), 32'd0);
        end
        tick();
        check("dr4_done", 32'(done), 32'd1);
        check("dr4_busy", 32'(busy), 32'd0);
        check("dr4_wr", 32'(mem_wr_en), 32'd0);
        tick();
        check("drmem20", 32'(mem[8'h20]), 32'd5);
        check("drmem21", 32'(mem[8'h21]), 32'd6);
        check("drmem22", 32'(mem[8'h22]), 32'd7);
        check("drmem23", 32'(mem[8'h23]), 32'd8);

        // Back-to-back start in the IDLE cycle after done; LOAD wrapping past 0xFF.
        start = 1'b1; mode = 1'b0; base_addr = 8'hFE;
        tick();
        start = 1'b0;
        check("wr0_busy", 32'(busy), 32'd1);
        for (int c = 0; c < 5; c++) begin
            if (c < 4) check("wr_addr", 32'(mem_addr), 32'((8'hFE + c) & 8'hFF));
            if (c >= 1) check("wr_dw", 32'(data_write), 32'(c));
            tick();
        end
        check("wr5_done", 32'(done), 32'd1);
        tick();

        // Reset in LOAD cycle 2 aborts with no done pulse.
        start = 1'b1; mode = 1'b0; base_addr = 8'h10;
        tick();
        start = 1'b0;
        tick(); tick();
        check("ab2_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("ab_busy", 32'(busy), 32'd0);
        check("ab_ctrl", 32'(ctrl_code), 32'd0);
        check("ab_rd", 32'(mem_rd_en), 32'd0);
        check("ab_done", 32'(done), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("ab_nodone", 32'(done), 32'd0);
            check("ab_idle", 32'(busy), 32'd0);
        end
        start = 1'b1; mode = 1'b0; base_addr = 8'h10;
        tick();
        start = 1'b0;
        check("re0_busy", 32'(busy), 32'd1);
        check("re0_addr", 32'(mem_addr), 32'h10);
        tick();
        check("re1_dw", 32'(data_write), 32'd5);
        tick(); tick(); tick();
        check("re4_dw", 32'(data_write), 32'd8);
        tick();
        check("re5_done", 32'(done), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
